// File: rtl/alu_defs.sv
// alu_defs: shared ALU/funct codes and the Hi/Lo sequencer state encoding.
package alu_defs;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [5:0] FUNCT_SLL   = 6'd0;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } seq_state_t;
endpackage

// File: rtl/multu_seq_ctrl.sv
// multu_seq_ctrl: launches MULTU, times the multiplier, strobes Hi/Lo and stalls Hi/Lo users.
module multu_seq_ctrl
    import alu_defs::*;
#(
    parameter int MUL_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    input  logic       flush,
    output logic       mult_start,
    output logic       mult_en,
    output logic       hilo_we,
    output logic       stall,
    output logic       busy
);
    seq_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rtype, is_multu, hilo_use, active, idle;

    assign rtype    = ex_valid && alu_op == ALUOP_RTYPE;
    assign is_multu = rtype && funct == FUNCT_MULTU;
    assign hilo_use = is_multu || (rtype && (funct == FUNCT_MFHI || funct == FUNCT_MFLO));
    // rst is active-low; every output is forced quiet while it is asserted
    assign active   = rst;
    assign idle     = state == IDLE;

    assign mult_start = active && idle && is_multu && !flush;
    assign mult_en    = active && state == RUN;
    assign hilo_we    = active && state == WRITE;
    assign stall      = active && !idle && hilo_use && !flush;
    assign busy       = active && !idle;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                state_n = mult_start ? RUN : IDLE;
                cnt_n   = mult_start ? CNT_W'(MUL_CYCLES - 1) : cnt;
            end
            RUN: begin
                state_n = cnt == '0 ? WRITE : RUN;
                cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
            end
            WRITE:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_multu_seq_ctrl.sv
// tb_multu_seq_ctrl: directed scenarios for the MULTU/Hi-Lo sequencer with MUL_CYCLES=32.
module tb_multu_seq_ctrl;
    localparam logic [5:0] F_MULTU = 6'd25, F_MFHI = 6'd16, F_MFLO = 6'd18, F_ADD = 6'd32, F_SLL = 6'd0;
    logic       clk = 1'b0, rst = 1'b0, ex_valid = 1'b0, flush = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic       mult_start, mult_en, hilo_we, stall, busy;
    logic [4:0] obs, exp;
    int         total = 0, bad = 0;

    multu_seq_ctrl #(.MUL_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_op(alu_op), .funct(funct), .flush(flush),
        .mult_start(mult_start), .mult_en(mult_en), .hilo_we(hilo_we), .stall(stall), .busy(busy)
    );

    always #5 clk = ~clk;
    assign obs = {mult_start, mult_en, hilo_we, stall, busy};

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f, input logic fl);
        ex_valid = v;
        alu_op   = op;
        funct    = f;
        flush    = fl;
    endtask

    task automatic nop();
        drive(1'b0, 2'b00, 6'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 2'b10, F_MULTU, 1'b0);
        #1;
        total++;
        if (obs !== 5'b0) begin bad++; $display("FAIL reset_first got=%b exp=%b", obs, 5'b0); end
        tick();
        tick();
        total++;
        if (obs !== 5'b0) begin bad++; $display("FAIL reset_held got=%b exp=%b", obs, 5'b0); end
        rst = 1'b1;
        nop();
        #1;
        total++;
        if (obs !== 5'b0) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, 5'b0); end
        tick();
    endtask

    task automatic test_single();
        for (int c = 0; c <= 46; c++) begin
            if (c == 10) drive(1'b1, 2'b10, F_MULTU, 1'b0); else nop();
            #1;
            exp = {c == 10, c >= 11 && c <= 42, c == 43, 1'b0, c >= 11 && c <= 43};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL single c=%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
    endtask

    task automatic test_mfhi();
        for (int c = 0; c <= 47; c++) begin
            if (c == 10) drive(1'b1, 2'b10, F_MULTU, 1'b0);
            else if (c >= 15 && c <= 44) drive(1'b1, 2'b10, F_MFHI, 1'b0);
            else nop();
            #1;
            exp = {c == 10, c >= 11 && c <= 42, c == 43, c >= 15 && c <= 43, c >= 11 && c <= 43};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL mfhi c=%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 80; c++) begin
            if (c >= 10 && c <= 44) drive(1'b1, 2'b10, F_MULTU, 1'b0); else nop();
            #1;
            exp = {c == 10 || c == 44,
                   (c >= 11 && c <= 42) || (c >= 45 && c <= 76),
                   c == 43 || c == 77,
                   c >= 11 && c <= 43,
                   (c >= 11 && c <= 43) || (c >= 45 && c <= 77)};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL b2b c=%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
    endtask

    task automatic test_flush_issue();
        for (int c = 0; c <= 13; c++) begin
            if (c == 10) drive(1'b1, 2'b10, F_MULTU, 1'b1); else nop();
            #1;
            total++;
            if (obs !== 5'b0) begin bad++; $display("FAIL flush_issue c=%0d got=%b exp=%b", c, obs, 5'b0); end
            tick();
        end
    endtask

    task automatic test_flush_run();
        for (int c = 0; c <= 46; c++) begin
            if (c == 10) drive(1'b1, 2'b10, F_MULTU, 1'b0);
            else if (c == 20) drive(1'b1, 2'b10, F_MFLO, 1'b1);
            else nop();
            #1;
            exp = {c == 10, c >= 11 && c <= 42, c == 43, 1'b0, c >= 11 && c <= 43};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL flush_run c=%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
    endtask

    task automatic test_reset_run();
        for (int c = 0; c <= 62; c++) begin
            rst = c != 25;
            if (c == 10 || c == 25) drive(1'b1, 2'b10, F_MULTU, 1'b0); else nop();
            #1;
            exp = {c == 10, c >= 11 && c <= 24, 1'b0, 1'b0, c >= 11 && c <= 24};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL reset_run c=%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
        rst = 1'b1;
    endtask

    task automatic test_non_hilo();
        for (int c = 0; c <= 47; c++) begin
            case (c)
                10:      drive(1'b1, 2'b10, F_MULTU, 1'b0);
                15:      drive(1'b1, 2'b10, F_ADD, 1'b0);
                16:      drive(1'b1, 2'b10, F_SLL, 1'b0);
                17:      drive(1'b1, 2'b00, F_MFLO, 1'b0);
                18:      drive(1'b0, 2'b10, F_MFHI, 1'b0);
                45:      drive(1'b1, 2'b00, F_MFLO, 1'b0);
                46:      drive(1'b1, 2'b00, F_MULTU, 1'b0);
                47:      drive(1'b1, 2'b10, F_MFLO, 1'b0);
                default: nop();
            endcase
            #1;
            exp = {c == 10, c >= 11 && c <= 42, c == 43, 1'b0, c >= 11 && c <= 43};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL non_hilo c=%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
        nop();
    endtask

    initial begin
        test_reset();
        test_single();
        test_mfhi();
        test_back_to_back();
        test_flush_issue();
        test_flush_run();
        test_reset_run();
        test_non_hilo();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multu_seq_ctrl.md
Name: multu_seq_ctrl

Overview:
- Sequencing controller for the multicycle unsigned multiplier and the Hi/Lo register pair in the EX stage of the pipelined CPU.
- Decodes the R-type funct of the instruction in EX and launches MULTU on the multiplier.
- Counts the multiplier's fixed latency, then issues the single Hi/Lo write strobe.
- Stalls the pipeline when MULTU, MFHI or MFLO reaches EX while a multiply is still in flight.

Parameters:
- MUL_CYCLES, 32, number of cycles the multiplier needs after the start cycle before its 64-bit result is valid.
- CNT_W, 6, counter width; must satisfy 2**CNT_W > MUL_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- ex_valid  in  1  the instruction in EX is valid (not a bubble).
- alu_op  in  2  ALUop of the EX instruction; 2'b10 = R-type.
- funct  in  6  funct field of the EX instruction.
- flush  in  1  kill the EX instruction this cycle (branch/exception squash).
- mult_start  out  1  one-cycle pulse; the multiplier latches dataA/dataB this cycle.
- mult_en  out  1  the multiplier iterates while high (SignaltoMULTU).
- hilo_we  out  1  one-cycle write strobe; Hi/Lo load the 64-bit product.
- stall  out  1  freeze IF/ID/EX and insert a bubble into MEM.
- busy  out  1  a multiply is in flight (state != IDLE).

Behaviour:
- Decode: is_multu = ex_valid & alu_op==2'b10 & funct==6'd25; is_mfhi uses funct 6'd16; is_mflo uses funct 6'd18.
- Decode: hilo_use = is_multu | is_mfhi | is_mflo.
- States: IDLE, RUN, WRITE. Registered state plus a CNT_W-bit down-counter cnt.
- IDLE:
  - issue = is_multu & !flush.
  - mult_start = issue (combinational, same cycle the operands sit in EX).
  - On issue: next state RUN, cnt <= MUL_CYCLES-1.
  - Otherwise stay in IDLE.
- RUN:
  - mult_en = 1 and cnt decrements each cycle.
  - When cnt==0: next state WRITE.
- WRITE: hilo_we = 1 for exactly this one cycle; next state IDLE.
- Timing: MULTU in EX at cycle T gives RUN in cycles T+1..T+MUL_CYCLES, WRITE at T+MUL_CYCLES+1, and IDLE at T+MUL_CYCLES+2.
- The issuing MULTU itself does not stall; it advances to MEM at T+1.
- stall = hilo_use & !flush & (state != IDLE). This is combinational.
  - An MFHI/MFLO in EX during WRITE still stalls one cycle. It reads Hi/Lo in the following IDLE cycle, after the write edge.
  - A MULTU arriving during RUN or WRITE stalls. It issues in the first IDLE cycle, back-to-back with no gap cycle.
- Non-Hi/Lo instructions never stall, in any state.
- flush:
  - Suppresses issue and stall in the same cycle.
  - Does not abort a multiply already in RUN/WRITE, because the owning MULTU has already left EX.
- Outputs are mutually consistent: mult_start and mult_en are never high together; hilo_we is high only in WRITE.
- busy = (state != IDLE).
- Reset (rst==0 at an edge): state <= IDLE, cnt <= 0.
  - Outputs while in reset: mult_start=0, mult_en=0, hilo_we=0, stall=0, busy=0, regardless of the other inputs.
  - Reset mid-RUN or in WRITE discards the product; no hilo_we is issued.
- Undefined alu_op/funct combinations decode as non-Hi/Lo and are ignored.

Decomposition:
- Shared package (alu_defs):
  - funct constants FUNCT_MULTU=6'd25, FUNCT_MFHI=6'd16, FUNCT_MFLO=6'd18, plus the existing AND/OR/ADD/SUB/SLT/SLL codes.
  - ALUOP_RTYPE=2'b10.
  - State encoding for IDLE/RUN/WRITE.
- No sub-module is required. The decoder, FSM and counter stay in one module, since a separate counter would be a thin wrapper.

Test Plan:
- Single MULTU (MUL_CYCLES=32) at cycle 10 -> mult_start=1 @10; mult_en=1 @11..42; hilo_we=1 @43 only; busy low again @44; stall never high.
- MFHI in EX at cycle 15 behind that MULTU -> stall=1 @15..43, stall=0 @44; exactly one hilo_we, at 43.
- Back-to-back MULTU, second arriving at cycle 11 -> stall @11..43; second mult_start @44; second hilo_we @77.
- MULTU with flush=1 at cycle 10 -> mult_start=0, busy stays 0.
- Flush during RUN at cycle 20 -> hilo_we still @43.
- rst=0 at cycle 25 mid-RUN -> next cycle state IDLE, busy=0, mult_en=0; hilo_we stays 0 through cycle 60.
- ADD (funct 32) and SLL (funct 0) in EX during RUN -> stall=0. MFLO with alu_op=2'b00 -> no stall, no issue.
